// File: rtl/hap_pkg.sv
// -----------------------------------------------------------------------------
// hap_pkg
//   Shared definitions for the Harvard Architecture Processor fetch/decode slice:
//   instruction width, opcode values, instruction field bit positions and the
//   fetch/decode state encoding.
// -----------------------------------------------------------------------------
package hap_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_AW  = 3;

    // Opcodes (instr[15:11])
    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_CMP = 5'h01;
    localparam logic [4:0] OP_MOV = 5'h02;
    localparam logic [4:0] OP_HLT = 5'h1F;

    // Instruction field positions; instr[1:0] carries no information
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 11;
    localparam int unsigned RD_MSB  = 10;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 5;
    localparam int unsigned RS2_MSB = 4;
    localparam int unsigned RS2_LSB = 2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/hap_regfile.sv
// -----------------------------------------------------------------------------
// hap_regfile
//   NREGS x DATA_W register file, two combinational read ports, one write port
//   updated on the rising clock edge. r0 always reads 0 and ignores writes.
//   Optional macro HAP_WB_BYPASS_EN: a read of the register being written in the
//   same cycle returns the write data instead of the stored value.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset (clears all registers)
//   we, wa, wd      write enable / address / data
//   ra1, ra2        read addresses
//   rd1, rd2        read data
// -----------------------------------------------------------------------------
module hap_regfile #(
    parameter int unsigned NREGS  = 8,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs[ra1];
`ifdef HAP_WB_BYPASS_EN
        if (we && (wa != '0) && (wa == ra1)) begin
            rd1 = wd;
        end
`endif
    end

    always_comb begin
        rd2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef HAP_WB_BYPASS_EN
        if (we && (wa != '0) && (wa == ra2)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: rtl/hap_fetch_decode.sv
// -----------------------------------------------------------------------------
// hap_fetch_decode
//   Fetch/decode stage: drives the synchronous instruction ROM address, decodes
//   the returned 16-bit instruction, reads both source operands from the
//   register file and presents {Opcode, Rd_addr, R1, R2, Pc_out} to execute
//   behind a valid/ready handshake. Accepts register writeback and branch
//   redirects; stops fetching once a HLT instruction is accepted.
//   Optional macro HAP_WB_BYPASS_EN: same-cycle writeback is forwarded to the
//   operand reads, and operands held during a stall track matching writebacks.
// Ports
//   Clk, Rst_n             clock, asynchronous active-low reset
//   Imem_addr / Imem_data  ROM address out, instruction in (one cycle later)
//   Br_taken / Br_target   redirect request and target address
//   Wb_en/Wb_addr/Wb_data  register writeback
//   Out_valid / Out_ready  handshake towards execute
//   Opcode, Rd_addr, R1, R2, Pc_out   presented decoded instruction
//   Halted                 HLT accepted, fetch stopped
// -----------------------------------------------------------------------------
module hap_fetch_decode
    import hap_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DATA_W = 3,
    parameter int unsigned NREGS  = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    output logic [PC_W-1:0]    Imem_addr,
    input  logic [INSTR_W-1:0] Imem_data,
    input  logic               Br_taken,
    input  logic [PC_W-1:0]    Br_target,
    input  logic               Wb_en,
    input  logic [REG_AW-1:0]  Wb_addr,
    input  logic [DATA_W-1:0]  Wb_data,
    output logic               Out_valid,
    input  logic               Out_ready,
    output logic [4:0]         Opcode,
    output logic [2:0]         Rd_addr,
    output logic [DATA_W-1:0]  R1,
    output logic [DATA_W-1:0]  R2,
    output logic [PC_W-1:0]    Pc_out,
    output logic               Halted
);

    state_t            state;
    logic [PC_W-1:0]   fetch_pc;   // address whose data is on Imem_data
    logic              f_ok;
    logic              br;
    logic              hlt_acc;
    logic              load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              unused_instr_bits;

`ifdef HAP_WB_BYPASS_EN
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
`endif

    always_comb begin
        rs1               = Imem_data[RS1_MSB:RS1_LSB];
        rs2               = Imem_data[RS2_MSB:RS2_LSB];
        unused_instr_bits = ^Imem_data[RS2_LSB-1:0];
    end

    // Redirects are ignored once halted; a redirect also suppresses HLT
    // acceptance and any load in the same cycle.
    always_comb begin
        f_ok      = (state == ST_RUN);
        br        = Br_taken && (state != ST_HALT);
        hlt_acc   = f_ok && Out_valid && Out_ready && (Opcode == OP_HLT) && !br;
        load      = f_ok && (!Out_valid || Out_ready) && !br && !hlt_acc;
        Imem_addr = br   ? Br_target :
                    load ? fetch_pc + PC_W'(1) : fetch_pc;
        Halted    = (state == ST_HALT);
    end

    hap_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .AW     (REG_AW)
    ) u_regfile (
        .clk   (Clk),
        .rst_n (Rst_n),
        .we    (Wb_en),
        .wa    (Wb_addr),
        .wd    (Wb_data),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_BOOT;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (hlt_acc) state <= ST_HALT;
                default: state <= ST_HALT;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_pc  <= '0;
            Out_valid <= 1'b0;
            Opcode    <= '0;
            Rd_addr   <= '0;
            R1        <= '0;
            R2        <= '0;
            Pc_out    <= '0;
`ifdef HAP_WB_BYPASS_EN
            rs1_q     <= '0;
            rs2_q     <= '0;
`endif
        end else begin
            // While stalled Imem_addr == fetch_pc, so the ROM re-reads the
            // same word and Imem_data stays stable.
            fetch_pc <= Imem_addr;
            if (br) begin
                Out_valid <= 1'b0;
            end else if (load) begin
                Out_valid <= 1'b1;
                Opcode    <= Imem_data[OPC_MSB:OPC_LSB];
                Rd_addr   <= Imem_data[RD_MSB:RD_LSB];
                R1        <= rd1;
                R2        <= rd2;
                Pc_out    <= fetch_pc;
`ifdef HAP_WB_BYPASS_EN
                rs1_q     <= rs1;
                rs2_q     <= rs2;
`endif
            end else if (Out_ready) begin
                Out_valid <= 1'b0;
`ifdef HAP_WB_BYPASS_EN
            end else if (Out_valid && Wb_en && (Wb_addr != '0)) begin
                if (Wb_addr == rs1_q) R1 <= Wb_data;
                if (Wb_addr == rs2_q) R2 <= Wb_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_hap_fetch_decode.sv
module tb_hap_fetch_decode;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [7:0]  Imem_addr;
    logic [15:0] Imem_data;
    logic        Br_taken;
    logic [7:0]  Br_target;
    logic        Wb_en;
    logic [2:0]  Wb_addr;
    logic [2:0]  Wb_data;
    logic        Out_valid;
    logic        Out_ready;
    logic [4:0]  Opcode;
    logic [2:0]  Rd_addr;
    logic [2:0]  R1;
    logic [2:0]  R2;
    logic [7:0]  Pc_out;
    logic        Halted;

    always #5 Clk = ~Clk;

    hap_fetch_decode #(
        .PC_W   (8),
        .DATA_W (3),
        .NREGS  (8)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Imem_addr (Imem_addr),
        .Imem_data (Imem_data),
        .Br_taken  (Br_taken),
        .Br_target (Br_target),
        .Wb_en     (Wb_en),
        .Wb_addr   (Wb_addr),
        .Wb_data   (Wb_data),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Opcode    (Opcode),
        .Rd_addr   (Rd_addr),
        .R1        (R1),
        .R2        (R2),
        .Pc_out    (Pc_out),
        .Halted    (Halted)
    );

    // Synchronous instruction ROM
    logic [15:0] mem [256];
    always @(posedge Clk) Imem_data <= mem[Imem_addr];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: which instruction is presented, the next
    // address to present, and a shadow copy of the registers.
    bit         mboot, mhalt, mv;
    logic [7:0] nxt, mpc;
    logic [4:0] mopc;
    logic [2:0] mrd, mrs1, mrs2, cap1, cap2;
    logic [2:0] sregs [8];

    task automatic model_reset();
        mboot = 1; mhalt = 0; mv = 0; nxt = 8'h00;
        for (int i = 0; i < 8; i++) sregs[i] = 3'd0;
    endtask

    task automatic compare_outputs();
        logic [2:0] e1, e2;
`ifdef HAP_WB_BYPASS_EN
        e1 = sregs[mrs1]; e2 = sregs[mrs2];
`else
        e1 = cap1; e2 = cap2;
`endif
        check_eq("out_valid", Out_valid, mv);
        check_eq("halted", Halted, mhalt);
        if (mv) begin
            check_eq("opcode", Opcode, mopc);
            check_eq("rd_addr", Rd_addr, mrd);
            check_eq("pc_out", Pc_out, mpc);
            check_eq("r1", R1, e1);
            check_eq("r2", R2, e2);
        end
    endtask

    // One clock cycle: drive at negedge, advance the model at posedge, compare at negedge.
    task automatic cyc(input logic rdy, input logic b, input logic [7:0] bt,
                       input logic we, input logic [2:0] wa, input logic [2:0] wd);
        logic [15:0] ins;
        Out_ready = rdy; Br_taken = b; Br_target = bt;
        Wb_en = we; Wb_addr = wa; Wb_data = wd;
        #1;
        if (mhalt) check_eq("addr_frozen", Imem_addr, nxt);
        else if (b) check_eq("addr_redirect", Imem_addr, bt);
        else if (!mboot && mv && !rdy) check_eq("addr_stall", Imem_addr, nxt);
        @(posedge Clk);
        if (mboot) begin
            mboot = 0;
            if (b) nxt = bt;
        end else if (!mhalt) begin
            if (b) begin
                mv = 0; nxt = bt;
            end else if (mv && rdy && mopc == 5'h1F) begin
                mhalt = 1; mv = 0;
            end else if (!mv || rdy) begin
                ins  = mem[nxt];
                mv   = 1;
                mpc  = nxt;
                mopc = ins[15:11];
                mrd  = ins[10:8];
                mrs1 = ins[7:5];
                mrs2 = ins[4:2];
                cap1 = sregs[mrs1];
                cap2 = sregs[mrs2];
                nxt  = nxt + 8'd1;
            end
        end
        if (we && wa != 3'd0) sregs[wa] = wd;
        @(negedge Clk);
        compare_outputs();
    endtask

    task automatic idle(input logic rdy);
        cyc(rdy, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0);
    endtask

    // Asynchronous reset pulse issued mid-cycle, released on a falling edge.
    task automatic pulse_reset();
        #2;
        Rst_n = 1'b0; Br_taken = 1'b0; Wb_en = 1'b0;
        #1;
        check_eq("rst_valid", Out_valid, 0);
        check_eq("rst_halted", Halted, 0);
        check_eq("rst_pc_out", Pc_out, 0);
        check_eq("rst_opcode", Opcode, 0);
        check_eq("rst_addr", Imem_addr, 0);
        model_reset();
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        logic [7:0]  epc;
        Rst_n = 1'b1; Out_ready = 1'b1; Br_taken = 1'b0; Br_target = '0;
        Wb_en = 1'b0; Wb_addr = '0; Wb_data = '0;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'h1F) w[15:11] = 5'h1E;
            mem[i] = w;
        end
        mem[8'h00] = 16'h08A4;                               // op 1, rd 0, rs1 5, rs2 1
        mem[8'h10] = {5'd2, 3'd1, 3'd5, 3'd0, 2'b01};        // reads r5, r0
        mem[8'h11] = {5'd2, 3'd1, 3'd0, 3'd0, 2'b11};        // reads r0, r0
        mem[8'h41] = {5'd3, 3'd2, 3'd3, 3'd3, 2'b00};        // reads r3, r3
        model_reset();
        #3 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;

        // Reset release: address sequence 0,1,2 and first valid two cycles later
        check_eq("t1_addr0", Imem_addr, 0);
        idle(1'b1);
        check_eq("t1_addr1", Imem_addr, 1);
        check_eq("t1_valid_c1", Out_valid, 0);
        idle(1'b1);
        check_eq("t1_addr2", Imem_addr, 2);
        check_eq("t1_valid_c2", Out_valid, 1);
        check_eq("t1_opcode", Opcode, 1);
        check_eq("t1_pc_out", Pc_out, 0);

        // Writeback then read; r0 writes ignored
        cyc(1'b1, 1'b1, 8'h10, 1'b1, 3'd5, 3'd6);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 3'd7);
        check_eq("t2_r1_r5", R1, 6);
        check_eq("t2_r2_r0", R2, 0);
        idle(1'b1);
        check_eq("t2_r0_a", R1, 0);
        check_eq("t2_r0_b", R2, 0);

        // Redirect to 0x40
        cyc(1'b1, 1'b1, 8'h40, 1'b1, 3'd3, 3'd2);
        check_eq("t4_valid_off", Out_valid, 0);
        idle(1'b1);
        check_eq("t4_valid", Out_valid, 1);
        check_eq("t4_pc_out", Pc_out, 8'h40);

        // Same-cycle writeback and decode of r3
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 3'd3, 3'd7);
        check_eq("t5_pc_out", Pc_out, 8'h41);
`ifdef HAP_WB_BYPASS_EN
        check_eq("t5_bypass_r1", R1, 7);
`else
        check_eq("t5_old_r1", R1, 2);
`endif

        // Three-cycle stall, then release
        repeat (3) begin
            idle(1'b0);
            check_eq("t3_hold_valid", Out_valid, 1);
            check_eq("t3_hold_pc", Pc_out, 8'h41);
        end
        idle(1'b1);
        check_eq("t3_next_pc", Pc_out, 8'h42);
        idle(1'b1);
        check_eq("t3_next_pc2", Pc_out, 8'h43);

        // PC wrap FF -> 00
        cyc(1'b1, 1'b1, 8'hFD, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            epc = 8'hFD + 8'(i);
            check_eq("wrap_pc", Pc_out, epc);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 8'($urandom),
                $urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom));
        end

        // HLT at 0xFF
        cyc(1'b1, 1'b1, 8'h20, 1'b0, 3'd0, 3'd0);
        idle(1'b1);
        mem[8'hFF] = {5'h1F, 11'h000};
        cyc(1'b1, 1'b1, 8'hFC, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 40 && !mhalt; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0);
        end
        check_eq("t6_halted", Halted, 1);
        check_eq("t6_addr_frozen", Imem_addr, 0);
        repeat (5) begin
            cyc($urandom_range(0, 1) == 1, 1'b1, 8'h55, 1'b1, 3'($urandom), 3'($urandom));
        end
        check_eq("t6_still_halted", Halted, 1);
        check_eq("t6_still_frozen", Imem_addr, 0);

        // Restart after reset, then reset again in the middle of a stall
        pulse_reset();
        idle(1'b1);
        idle(1'b1);
        check_eq("t6_restart_valid", Out_valid, 1);
        check_eq("t6_restart_pc", Pc_out, 0);
        repeat (3) idle(1'b1);
        idle(1'b0);
        check_eq("t6_stall_valid", Out_valid, 1);
        pulse_reset();
        idle(1'b1);
        idle(1'b1);
        check_eq("t6_after_rst_valid", Out_valid, 1);
        check_eq("t6_after_rst_pc", Pc_out, 0);
        check_eq("t6_after_rst_op", Opcode, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
